// File: rtl/rev_conv_pkg.sv
// ============================================================================
// Module      : rev_conv_pkg
// Description : Shared types and helpers for the MRC-to-binary sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rev_conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } mrc_state_t;

    // Accumulator width: carry word concatenated above the low word.
    function automatic int unsigned calc_acc_w(input int unsigned op_w,
                                               input int unsigned carry_w);
        return op_w + carry_w;
    endfunction

    // A most-significant digit at or above this value marks a negative number.
    function automatic logic [31:0] mrc_sign_thresh(input logic [31:0] m);
        return (m + 32'd1) >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mrc_mac_step.sv
// ============================================================================
// Module      : mrc_mac_step
// Description : Two-cycle Horner step: registered acc*m, then registered +d.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mrc_mac_step #(
    parameter int ACC_W       = 24,
    parameter int MOD_WIDTH   = 8,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [ACC_W-1:0]       i_load_val,
    input  logic                   i_mul,
    input  logic                   i_add,
    input  logic [MOD_WIDTH-1:0]   i_mod,
    input  logic [DIGIT_WIDTH-1:0] i_digit,
    output logic [ACC_W-1:0]       o_sum,
    output logic                   o_ovf
);

    localparam int c_prod_w = ACC_W + MOD_WIDTH;
    localparam int c_sum_w  = ACC_W + 1;

    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_prod;
    logic                r_ovf;
    logic [c_prod_w-1:0] w_full;
    logic [c_sum_w-1:0]  w_sum;

    assign w_full = c_prod_w'(r_acc) * c_prod_w'(i_mod);
    assign w_sum  = {1'b0, r_prod} + c_sum_w'(i_digit);
    assign o_sum  = w_sum[ACC_W-1:0];
    assign o_ovf  = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_prod <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (i_load) begin
                r_acc <= i_load_val;
            end
            if (i_mul) begin
                r_prod <= w_full[ACC_W-1:0];
                if (|w_full[c_prod_w-1:ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end
            if (i_add) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W]) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rev_conv_mrc_seq.sv
// ============================================================================
// Module      : rev_conv_mrc_seq
// Description : Sequential MRC-to-binary converter feeding the 3-input adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rev_conv_mrc_seq
    import rev_conv_pkg::*;
#(
    parameter int                            NUM_DIGITS  = 4,
    parameter int                            DIGIT_WIDTH = 8,
    parameter int                            MOD_WIDTH   = 8,
    parameter logic [NUM_DIGITS*MOD_WIDTH-1:0] MODULI    = {8'd11, 8'd7, 8'd5, 8'd3},
    parameter int                            OP_WIDTH    = 16,
    parameter int                            CARRY_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] in_digits,
    output logic                              out_valid,
    output logic [CARRY_WIDTH-1:0]            carry_out,
    output logic [OP_WIDTH-1:0]               b_out,
    output logic                              enable_bin,
    output logic                              ovf,
    output logic                              busy
);

    localparam int ACC_W     = calc_acc_w(OP_WIDTH, CARRY_WIDTH);
    localparam int c_k_w     = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS - 1) : 1;
    localparam logic [c_k_w-1:0] c_k_start = c_k_w'(NUM_DIGITS - 2);
    localparam logic [31:0] c_msd_thresh =
        mrc_sign_thresh(32'(MODULI[(NUM_DIGITS-1)*MOD_WIDTH +: MOD_WIDTH]));

    mrc_state_t                        r_state;
    mrc_state_t                        w_state_nxt;
    logic [c_k_w-1:0]                  r_k;
    logic [NUM_DIGITS*DIGIT_WIDTH-1:0] r_digits;
    logic                              r_neg;
    logic                              r_out_valid;
    logic [CARRY_WIDTH-1:0]            r_carry;
    logic [OP_WIDTH-1:0]               r_b;
    logic                              r_enable_bin;

    logic                   w_accept;
    logic                   w_mul;
    logic                   w_add;
    logic [DIGIT_WIDTH-1:0] w_msd;
    logic [MOD_WIDTH-1:0]   w_mod;
    logic [DIGIT_WIDTH-1:0] w_digit;
    logic [ACC_W-1:0]       w_sum;
    logic                   w_ovf;

    assign in_ready   = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign w_accept   = in_valid & in_ready;
    assign w_msd      = in_digits[(NUM_DIGITS-1)*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign w_mod      = MODULI[r_k*MOD_WIDTH +: MOD_WIDTH];
    assign w_digit    = r_digits[r_k*DIGIT_WIDTH +: DIGIT_WIDTH];
    assign out_valid  = r_out_valid;
    assign carry_out  = r_carry;
    assign b_out      = r_b;
    assign enable_bin = r_enable_bin;
    assign ovf        = w_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_mul       = 1'b0;
        w_add       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = MUL;
                end
            end
            MUL: begin
                w_mul       = 1'b1;
                w_state_nxt = ADD;
            end
            ADD: begin
                w_add       = 1'b1;
                w_state_nxt = (r_k == '0) ? IDLE : MUL;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_digits     <= '0;
            r_neg        <= 1'b0;
            r_out_valid  <= 1'b0;
            r_carry      <= '0;
            r_b          <= '0;
            r_enable_bin <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_digits <= in_digits;
                r_k      <= c_k_start;
                r_neg    <= (32'(w_msd) >= c_msd_thresh);
            end
            // The final ADD publishes the sum being written into the accumulator.
            if (w_add) begin
                if (r_k == '0) begin
                    r_out_valid  <= 1'b1;
                    r_carry      <= w_sum[ACC_W-1:OP_WIDTH];
                    r_b          <= w_sum[OP_WIDTH-1:0];
                    r_enable_bin <= r_neg;
                end else begin
                    r_k <= r_k - 1'b1;
                end
            end
        end
    end

    mrc_mac_step #(
        .ACC_W       (ACC_W),
        .MOD_WIDTH   (MOD_WIDTH),
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_mac (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_accept),
        .i_load_val (ACC_W'(w_msd)),
        .i_mul      (w_mul),
        .i_add      (w_add),
        .i_mod      (w_mod),
        .i_digit    (w_digit),
        .o_sum      (w_sum),
        .o_ovf      (w_ovf)
    );

endmodule

`default_nettype wire

// File: doc/rev_conv_mrc_seq.md
Name: rev_conv_mrc_seq

Overview:
- Upstream feeder for the 3-input reverse-converter adder (bin_add_const_3x2).
- Takes one vector of mixed-radix (MRC) digits and evaluates the binary value with Horner's rule, one multiply-accumulate per digit over two cycles.
- Presents the result split as carry word (-> in_a) and low word (-> in_b), with a sign-correction enable (-> enable_bin).
- MRC sign detection uses the most significant digit; the downstream stage then adds its constant (range offset) when the value is negative.

Parameters:
- NUM_DIGITS, 4, number of mixed-radix digits; must be >= 2.
- DIGIT_WIDTH, 8, bits per digit.
- MOD_WIDTH, 8, bits per modulus.
- MODULI, {8'd11,8'd7,8'd5,8'd3}, packed NUM_DIGITS*MOD_WIDTH; slice k = modulus m_k, with k=0 in the LSBs.
- OP_WIDTH, 16, low-word width; equals downstream OP_WIDTH.
- CARRY_WIDTH, 8, carry-word width; equals downstream CARRY_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  digit vector valid.
- in_ready  out  1  block can accept a vector.
- in_digits  in  NUM_DIGITS*DIGIT_WIDTH  digit k in slice k; digit NUM_DIGITS-1 is most significant.
- out_valid  out  1  one-cycle pulse; carry_out, b_out and enable_bin are valid.
- carry_out  out  CARRY_WIDTH  acc[ACC_W-1:OP_WIDTH] -> adder in_a.
- b_out  out  OP_WIDTH  acc[OP_WIDTH-1:0] -> adder in_b.
- enable_bin  out  1  value is negative; adder adds its constant.
- ovf  out  1  sticky: an intermediate value exceeded ACC_W.
- busy  out  1  state != IDLE.

Behaviour:
- ACC_W = OP_WIDTH + CARRY_WIDTH. Value computed: X = d0 + d1*m0 + d2*m0*m1 + ...
- FSM has three states: IDLE, MUL, ADD. in_ready = (state == IDLE).
- Accept (in_valid & in_ready at an edge):
  - latch the digits;
  - acc <= d_{N-1}, zero-extended;
  - k <= N-2;
  - neg <= (d_{N-1} >= (m_{N-1}+1)>>1);
  - state -> MUL.
- MUL: prod <= acc * m_k, computed at full width ACC_W+MOD_WIDTH. If the upper bits are nonzero, set ovf. Keep the low ACC_W bits. State -> ADD.
- ADD: acc <= prod + d_k. If the sum carries out of ACC_W, set ovf.
  - k != 0: k <= k-1, state -> MUL.
  - k == 0: register carry_out, b_out and enable_bin <= neg; out_valid <= 1; state -> IDLE.
- Latency: out_valid is high in the cycle after edge 2(N-1) counted from the accept edge. For N=4 that is 6 edges.
- Throughput: a new accept is allowed on the edge after out_valid rises. The minimum accept-to-accept spacing is 2(N-1)+1 edges.
- out_valid lasts exactly one cycle. There is no backpressure: the downstream pipeline is fixed-latency.
- carry_out, b_out and enable_bin hold their value until the next completion.
- in_valid while busy is ignored; no vector is captured.
- Digits >= their modulus are not checked. The arithmetic result is then undefined, but ovf still reflects width overflow.
- ovf clears only on reset. It is set at the same edge as the offending register update.
- Reset (any cycle, including mid-conversion):
  - state IDLE, in_ready = 1, busy = 0;
  - out_valid, carry_out, b_out, enable_bin, ovf, acc, prod, k, neg all 0;
  - any partial conversion is discarded and never produces out_valid.
- in_valid asserted in the same cycle as reset is not accepted.

Decomposition:
- rev_conv_pkg holds:
  - function mrc_sign_thresh(m) = (m+1)>>1;
  - localparam helper ACC_W = OP_WIDTH + CARRY_WIDTH;
  - FSM enum typedef mrc_state_t {IDLE, MUL, ADD}.
- One sub-module is natural: mrc_mac_step (registered multiply, then registered add, with the overflow flags). It is instantiated once; the sequencer muxes m_k and d_k into it.

Test Plan (MODULI={11,7,5,3}, OP_WIDTH=8, CARRY_WIDTH=4 unless noted):
- Digits (d3..d0) = (2,4,1,2), X=275 -> out_valid 6 cycles after accept; carry_out=0x1, b_out=0x13, enable_bin=0, ovf=0.
- Digits (6,0,0,0), X=630 -> carry_out=0x2, b_out=0x76, enable_bin=1 (6 >= threshold 6). Digits (5,6,4,2) -> enable_bin=0 (boundary).
- Max digits (10,6,4,2), X=1154 -> carry_out=0x4, b_out=0x82, enable_bin=1. Same vector with CARRY_WIDTH=2 (ACC_W=10) -> ovf=1, sticky across the next clean conversion.
- in_valid held high continuously with alternating vectors -> accepts exactly 7 edges apart; in_ready=0 for 6 cycles after each accept; no extra out_valid pulses.
- Reset asserted at cycle 3 of a conversion -> no out_valid; all outputs 0 and in_ready=1 next cycle. The next vector (2,4,1,2) converts correctly to 0x1/0x13.
- in_valid asserted together with reset -> not accepted; busy stays 0.
